// File: rtl/jtbubl_mcubus_if.sv
// jtbubl_mcubus_if: MCU port, shared RAM and host interrupt signals of the MCU bridge
interface jtbubl_mcubus_if #(
    parameter int AW = 12,
    parameter int RW = 10
);
    logic          cen;
    logic [AW-1:0] mcu_addr;
    logic          mcu_strobe;
    logic          mcu_wr_n;
    logic [7:0]    mcu_dout;
    logic [7:0]    ram_q;
    logic [RW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic          ram_sel;
    logic [7:0]    mcu_rdata;
    logic [7:0]    int_vector;
    logic          irq_trig;
    logic          mcu_irq;
    logic          host_int_src;
    logic          host_ack;
    logic          host_int_n;

    modport master(
        output cen, mcu_addr, mcu_strobe, mcu_wr_n, mcu_dout, ram_q, irq_trig, host_int_src, host_ack,
        input  ram_addr, ram_we, ram_din, ram_sel, mcu_rdata, int_vector, mcu_irq, host_int_n
    );

    modport slave(
        input  cen, mcu_addr, mcu_strobe, mcu_wr_n, mcu_dout, ram_q, irq_trig, host_int_src, host_ack,
        output ram_addr, ram_we, ram_din, ram_sel, mcu_rdata, int_vector, mcu_irq, host_int_n
    );
endinterface

// File: rtl/jtbubl_mcubus.sv
// jtbubl_mcubus: strobe-driven bridge from MCU ports to shared RAM, vector latch, MCU IRQ and host INT
module jtbubl_mcubus #(
    parameter int                AW       = 12,
    parameter int                RW       = 10,
    parameter logic [AW-RW-1:0]  WIN      = 2'b11,
    parameter logic [RW-1:0]     VEC_ADDR = '0,
    parameter logic [7:0]        VEC_RST  = 8'h2E,
    parameter int                IRQLEN   = 16,
    parameter int                INTTO    = 0
) (
    input logic           clk,
    input logic           rst,
    jtbubl_mcubus_if.slave bus
);
    localparam int CW = IRQLEN > 1 ? $clog2(IRQLEN) : 1;
    localparam int TW = INTTO > 1 ? $clog2(INTTO) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(IRQLEN - 1);
    localparam logic [TW-1:0] TO_END  = TW'(INTTO > 0 ? INTTO - 1 : 0);

    logic          armed;
    logic          strobe_l;
    logic          trig_l;
    logic          src_l;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          stb_edge;
    logic          trig_edge;
    logic          src_edge;
    logic          in_win;

    // armed masks the first cen after reset so stale tracker values never fire
    assign stb_edge  = bus.cen & armed & bus.mcu_strobe & ~strobe_l;
    assign trig_edge = bus.cen & armed & ~bus.irq_trig & trig_l;
    assign src_edge  = bus.cen & armed & bus.host_int_src & ~src_l;
    assign in_win    = bus.mcu_addr[AW-1:RW] == WIN;
    assign bus.mcu_rdata = bus.ram_sel ? bus.ram_q : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b0;
            strobe_l <= 1'b1;
            trig_l   <= 1'b1;
            src_l    <= 1'b0;
        end else if (bus.cen) begin
            armed    <= 1'b1;
            strobe_l <= bus.mcu_strobe;
            trig_l   <= bus.irq_trig;
            src_l    <= bus.host_int_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_we     <= 1'b0;
            bus.ram_sel    <= 1'b0;
            bus.ram_din    <= 8'h00;
            bus.ram_addr   <= '0;
            bus.int_vector <= VEC_RST;
        end else if (stb_edge) begin
            bus.ram_sel <= in_win;
            bus.ram_we  <= in_win & ~bus.mcu_wr_n;
            if (in_win) begin
                bus.ram_addr <= bus.mcu_addr[RW-1:0];
                bus.ram_din  <= bus.mcu_dout;
                if (!bus.mcu_wr_n && bus.mcu_addr[RW-1:0] == VEC_ADDR)
                    bus.int_vector <= bus.mcu_dout;
            end
        end else if (bus.cen) begin
            bus.ram_we <= 1'b0;
        end
    end

    // a new request restarts the count, stretching rather than doubling the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mcu_irq <= 1'b0;
            cnt         <= '0;
        end else if (trig_edge) begin
            bus.mcu_irq <= 1'b1;
            cnt         <= '0;
        end else if (bus.cen && bus.mcu_irq) begin
            if (cnt == CNT_END)
                bus.mcu_irq <= 1'b0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // ack is checked before cen so it clears immediately and swallows a coincident edge
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.host_int_n <= 1'b1;
            tcnt           <= '0;
        end else if (bus.host_ack) begin
            bus.host_int_n <= 1'b1;
            tcnt           <= '0;
        end else if (src_edge) begin
            bus.host_int_n <= 1'b0;
            tcnt           <= '0;
        end else if (INTTO > 0 && bus.cen && !bus.host_int_n) begin
            if (tcnt == TO_END)
                bus.host_int_n <= 1'b1;
            else
                tcnt <= tcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_jtbubl_mcubus.sv
// tb_jtbubl_mcubus: directed checks of the MCU bridge with IRQLEN=16, INTTO=8
module tb_jtbubl_mcubus;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   n;

    always #5 clk = ~clk;

    jtbubl_mcubus_if #(.AW(12), .RW(10)) bus();

    jtbubl_mcubus #(.IRQLEN(16), .INTTO(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // one cen period: a cen clock followed by one idle clock
    task automatic tick();
        bus.cen = 1'b1;
        clk1();
        bus.cen = 1'b0;
        clk1();
    endtask

    task automatic strobe(input logic [11:0] a, input logic [7:0] d, input logic wr_n);
        bus.mcu_addr   = a;
        bus.mcu_dout   = d;
        bus.mcu_wr_n   = wr_n;
        bus.mcu_strobe = 1'b1;
        tick();
    endtask

    task automatic release_strobe();
        bus.mcu_strobe = 1'b0;
        tick();
    endtask

    initial begin
        bus.cen = 0; bus.mcu_addr = 0; bus.mcu_strobe = 0; bus.mcu_wr_n = 1; bus.mcu_dout = 0;
        bus.ram_q = 0; bus.irq_trig = 1; bus.host_int_src = 0; bus.host_ack = 0;
        rst = 1;
        clk1(); clk1();
        check("rst_we", bus.ram_we, 0);
        check("rst_sel", bus.ram_sel, 0);
        check("rst_din", bus.ram_din, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_vec", bus.int_vector, 8'h2E);
        check("rst_irq", bus.mcu_irq, 0);
        check("rst_int", bus.host_int_n, 1);
        check("rst_rdata", bus.mcu_rdata, 8'hFF);
        rst = 0;
        tick();

        strobe(12'hC05, 8'h5A, 0);
        check("wr_we", bus.ram_we, 1);
        check("wr_addr", bus.ram_addr, 10'h005);
        check("wr_din", bus.ram_din, 8'h5A);
        check("wr_sel", bus.ram_sel, 1);
        release_strobe();
        check("wr_we_drop", bus.ram_we, 0);
        check("wr_vec_keep", bus.int_vector, 8'h2E);

        strobe(12'hC00, 8'h38, 0);
        check("vec_load", bus.int_vector, 8'h38);
        release_strobe();
        strobe(12'h800, 8'h11, 0);
        check("vec_out_keep", bus.int_vector, 8'h38);
        check("out_sel", bus.ram_sel, 0);
        check("out_we", bus.ram_we, 0);
        release_strobe();

        bus.ram_q = 8'hA7;
        strobe(12'hC10, 8'h00, 1);
        check("rd_sel", bus.ram_sel, 1);
        check("rd_data", bus.mcu_rdata, 8'hA7);
        check("rd_we", bus.ram_we, 0);
        check("rd_addr", bus.ram_addr, 10'h010);
        release_strobe();
        strobe(12'h002, 8'h00, 1);
        check("rd_ff", bus.mcu_rdata, 8'hFF);
        release_strobe();

        strobe(12'hFFF, 8'h77, 0);
        check("top_addr", bus.ram_addr, 10'h3FF);
        check("top_we", bus.ram_we, 1);
        release_strobe();
        strobe(12'hBFF, 8'h66, 0);
        check("below_win_we", bus.ram_we, 0);
        check("below_win_addr", bus.ram_addr, 10'h3FF);
        release_strobe();

        bus.irq_trig = 0;
        tick();
        bus.irq_trig = 1;
        check("irq_set", bus.mcu_irq, 1);
        n = 1;
        for (int k = 1; k < 60; k++) begin
            tick();
            if (bus.mcu_irq) n++;
            else break;
        end
        check("irq_len", n, 16);

        bus.irq_trig = 0;
        tick();
        bus.irq_trig = 1;
        n = 1;
        for (int k = 1; k < 60; k++) begin
            if (k == 5) bus.irq_trig = 0;
            tick();
            if (bus.mcu_irq) n++;
            else break;
        end
        bus.irq_trig = 1;
        check("irq_ext_len", n, 21);
        tick();

        bus.host_int_src = 1;
        tick();
        check("int_set", bus.host_int_n, 0);
        bus.host_ack = 1;
        clk1();
        bus.host_ack = 0;
        check("int_ack", bus.host_int_n, 1);
        bus.host_int_src = 0;
        tick();
        bus.host_int_src = 1;
        tick();
        check("int_set2", bus.host_int_n, 0);
        n = 1;
        for (int k = 1; k < 40; k++) begin
            tick();
            if (!bus.host_int_n) n++;
            else break;
        end
        check("int_timeout", n, 8);
        bus.host_int_src = 0;
        tick();
        bus.host_int_src = 1;
        bus.host_ack = 1;
        tick();
        bus.host_ack = 0;
        check("int_ack_wins", bus.host_int_n, 1);
        tick();
        check("int_edge_lost", bus.host_int_n, 1);
        bus.host_int_src = 0;
        tick();

        bus.mcu_addr = 12'hC00; bus.mcu_dout = 8'h99; bus.mcu_wr_n = 0;
        bus.mcu_strobe = 1; bus.irq_trig = 0; bus.host_int_src = 1;
        bus.cen = 1;
        clk1();
        bus.cen = 0;
        check("pre_rst_we", bus.ram_we, 1);
        check("pre_rst_vec", bus.int_vector, 8'h99);
        check("pre_rst_irq", bus.mcu_irq, 1);
        check("pre_rst_int", bus.host_int_n, 0);
        rst = 1;
        clk1();
        check("mid_rst_we", bus.ram_we, 0);
        check("mid_rst_vec", bus.int_vector, 8'h2E);
        check("mid_rst_irq", bus.mcu_irq, 0);
        check("mid_rst_int", bus.host_int_n, 1);
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_we", bus.ram_we, 0);
        end
        check("post_rst_vec", bus.int_vector, 8'h2E);
        check("post_rst_irq", bus.mcu_irq, 0);
        check("post_rst_int", bus.host_int_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
